// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: alignment mode
// encoding and saturating duty arithmetic.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Add or subtract step from val, saturating at 0 below and limit above.
    // With step = 0 and down = 0 this is a plain clamp to limit.
    function automatic int unsigned sat_step(
        input int unsigned val,
        input int unsigned step,
        input int unsigned limit,
        input logic        down
    );
        if (down) begin
            return (val < step) ? 0 : (val - step);
        end
        return ((val + step) > limit) ? limit : (val + step);
    endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Tick-sampled two-flop button debouncer producing a one-cycle press pulse.
module pwm_btn_debounce (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic press
);

    logic q1;
    logic q2;

    // Sample the raw button level on each debounce tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else if (tick) begin
            q1 <= btn;
            q2 <= q1;
        end
    end

    // Rising edge of the sampled level, qualified so it lasts one clk cycle.
    always_comb begin
        press = q1 & ~q2 & tick;
    end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator: debounced inc/dec buttons, direct duty
// write, period-synchronous duty update and edge/center alignment.
module pwm_multi_ctrl
    import pwm_pkg::*;
#(
    parameter  int NUM_CH         = 4,
    parameter  int PERIOD         = 100,
    parameter  int CNT_W          = $clog2(PERIOD + 1),
    parameter  int STEP           = 10,
    parameter  int DUTY_INIT      = 50,
    parameter  int DEBOUNCE_TICKS = 250000,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         btn_inc,
    input  logic [NUM_CH-1:0]         btn_dec,
    input  logic [NUM_CH-1:0]         mode,
    input  logic                      wr_en,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [CNT_W-1:0]          wr_data,
    output logic [NUM_CH-1:0]         pwm_out,
    output logic                      period_start,
    output logic [NUM_CH*CNT_W-1:0]   duty_rd
);

    localparam int TW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    logic [TW-1:0]     div;
    logic              tick;
    logic [CNT_W-1:0]  cnt;
    logic              at_end;
    logic [NUM_CH-1:0] inc_press;
    logic [NUM_CH-1:0] dec_press;
    logic [CNT_W-1:0]  shadow    [NUM_CH];
    logic [CNT_W-1:0]  shadow_nx [NUM_CH];
    logic [CNT_W-1:0]  active    [NUM_CH];
    logic [CNT_W-1:0]  off       [NUM_CH];
    logic [NUM_CH-1:0] hit;

    assign tick   = (div == TW'(DEBOUNCE_TICKS - 1));
    assign at_end = (cnt == CNT_W'(PERIOD - 1));

    // Debounce tick divider, wrapping after DEBOUNCE_TICKS cycles.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Shared period counter 0..PERIOD-1.
    always_ff @(posedge clk) begin
        if (rst || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_btn
        pwm_btn_debounce u_inc (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .btn   (btn_inc[c]),
            .press (inc_press[c])
        );
        pwm_btn_debounce u_dec (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .btn   (btn_dec[c]),
            .press (dec_press[c])
        );
    end

    // Next shadow duty: direct write beats buttons; opposing presses cancel.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            shadow_nx[c] = shadow[c];
            if (wr_en && (wr_ch == CH_W'(c))) begin
                shadow_nx[c] = CNT_W'(sat_step(32'(wr_data), 0, PERIOD, 1'b0));
            end else if (inc_press[c] && dec_press[c]) begin
                shadow_nx[c] = shadow[c];
            end else if (inc_press[c]) begin
                shadow_nx[c] = CNT_W'(sat_step(32'(shadow[c]), STEP, PERIOD, 1'b0));
            end else if (dec_press[c]) begin
                shadow_nx[c] = CNT_W'(sat_step(32'(shadow[c]), STEP, PERIOD, 1'b1));
            end
        end
    end

    // Shadow follows requests every cycle; active copies it only at period end.
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                shadow[c] <= CNT_W'(DUTY_INIT);
                active[c] <= CNT_W'(DUTY_INIT);
            end else begin
                shadow[c] <= shadow_nx[c];
                if (at_end) begin
                    active[c] <= shadow[c];
                end
            end
        end
    end

    // Per-channel compare against the shared counter.
    always_comb begin
        hit = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            off[c] = (CNT_W'(PERIOD) - active[c]) >> 1;
            if (pwm_mode_e'(mode[c]) == PWM_CENTER) begin
                hit[c] = (cnt >= off[c]) && (cnt < (off[c] + active[c]));
            end else begin
                hit[c] = (cnt < active[c]);
            end
        end
    end

    // Registered outputs, one cycle behind the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= hit;
            period_start <= (cnt == '0);
        end
    end

    // Readback of the duty currently driving each channel.
    always_comb begin
        duty_rd = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            duty_rd[c*CNT_W +: CNT_W] = active[c];
        end
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Randomized and directed bench for pwm_multi_ctrl against a behavioural model.
module tb_pwm_multi_ctrl;

    localparam int NUM_CH = 4;
    localparam int PERIOD = 100;
    localparam int CNT_W  = 7;
    localparam int STEP   = 10;
    localparam int INIT   = 50;
    localparam int DT     = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       btn_inc;
    logic [NUM_CH-1:0]       btn_dec;
    logic [NUM_CH-1:0]       mode;
    logic                    wr_en;
    logic [1:0]              wr_ch;
    logic [CNT_W-1:0]        wr_data;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    period_start;
    logic [NUM_CH*CNT_W-1:0] duty_rd;

    int total = 0;
    int bad   = 0;

    // Model state: cycles since reset, sampled button history, duties.
    int          n;
    bit          s1 [2*NUM_CH];
    bit          s2 [2*NUM_CH];
    int          shadow [NUM_CH];
    int          active [NUM_CH];
    bit [NUM_CH-1:0] e_pwm;
    bit          e_ps;

    pwm_multi_ctrl #(
        .NUM_CH         (NUM_CH),
        .PERIOD         (PERIOD),
        .CNT_W          (CNT_W),
        .STEP           (STEP),
        .DUTY_INIT      (INIT),
        .DEBOUNCE_TICKS (DT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .mode         (mode),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_data      (wr_data),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_rd      (duty_rd)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_high(input int cnt, input int d, input bit center);
        int o;
        if (!center) return cnt < d;
        o = (PERIOD - d) / 2;
        return (cnt >= o) && (cnt < o + d);
    endfunction

    function automatic int duty_of(input int c);
        logic [CNT_W-1:0] v;
        v = duty_rd[c*CNT_W +: CNT_W];
        return int'(v);
    endfunction

    // Advance the model across one clock edge using the inputs the DUT sees.
    task automatic model_edge();
        int cnt;
        bit tk;
        bit pr [2*NUM_CH];
        bit lvl;
        if (rst) begin
            n = 0;
            for (int b = 0; b < 2*NUM_CH; b++) begin
                s1[b] = 0;
                s2[b] = 0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c] = INIT;
                active[c] = INIT;
            end
            e_pwm = '0;
            e_ps  = 0;
            return;
        end
        cnt = n % PERIOD;
        tk  = (n % DT) == DT - 1;
        for (int c = 0; c < NUM_CH; c++) e_pwm[c] = ref_high(cnt, active[c], mode[c]);
        e_ps = (cnt == 0);
        for (int b = 0; b < 2*NUM_CH; b++) begin
            lvl   = (b < NUM_CH) ? btn_inc[b] : btn_dec[b-NUM_CH];
            pr[b] = tk && s1[b] && !s2[b];
            if (tk) begin
                s2[b] = s1[b];
                s1[b] = lvl;
            end
        end
        if (cnt == PERIOD - 1) begin
            for (int c = 0; c < NUM_CH; c++) active[c] = shadow[c];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && (int'(wr_ch) == c)) begin
                shadow[c] = (int'(wr_data) > PERIOD) ? PERIOD : int'(wr_data);
            end else if (pr[c] && pr[c+NUM_CH]) begin
                shadow[c] = shadow[c];
            end else if (pr[c]) begin
                shadow[c] = (shadow[c] + STEP > PERIOD) ? PERIOD : shadow[c] + STEP;
            end else if (pr[c+NUM_CH]) begin
                shadow[c] = (shadow[c] < STEP) ? 0 : shadow[c] - STEP;
            end
        end
        n++;
    endtask

    task automatic compare_all();
        logic [NUM_CH*CNT_W-1:0] ed;
        ed = '0;
        for (int c = 0; c < NUM_CH; c++) ed[c*CNT_W +: CNT_W] = CNT_W'(active[c]);
        check_val("pwm_out", 64'(pwm_out), 64'(e_pwm));
        check_val("period_start", 64'(period_start), 64'(e_ps));
        check_val("duty_rd", 64'(duty_rd), 64'(ed));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_ps();
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!period_start && k < 250);
        if (!period_start) check_val("period_start_timeout", 64'd0, 64'd1);
    endtask

    // Count one full period of channel ch; optionally write wv to wc at count wat.
    task automatic measure(input int ch, input int wat, input int wc, input int wv,
                           output int highs, output int first, output int last);
        wait_ps();
        highs = 0;
        first = -1;
        last  = -1;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) cycle();
            if (pwm_out[ch]) begin
                highs++;
                if (first < 0) first = i;
                last = i;
            end
            wr_en = (wat >= 0) && (n % PERIOD == wat);
            wr_ch = 2'(wc);
            wr_data = CNT_W'(wv);
        end
        wr_en = 0;
    endtask

    task automatic write(input int c, input int v);
        wr_en = 1;
        wr_ch = 2'(c);
        wr_data = CNT_W'(v);
        cycle();
        wr_en = 0;
    endtask

    task automatic press(input int b);
        if (b < NUM_CH) btn_inc[b] = 1; else btn_dec[b-NUM_CH] = 1;
        repeat (3*DT) cycle();
        if (b < NUM_CH) btn_inc[b] = 0; else btn_dec[b-NUM_CH] = 0;
        repeat (3*DT) cycle();
    endtask

    initial begin
        int h, f, l, ps_cnt;
        logic [NUM_CH*CNT_W-1:0] init_vec;
        rst = 1; btn_inc = '0; btn_dec = '0; mode = '0;
        wr_en = 0; wr_ch = '0; wr_data = '0;
        init_vec = '0;
        for (int c = 0; c < NUM_CH; c++) init_vec[c*CNT_W +: CNT_W] = CNT_W'(INIT);

        repeat (3) cycle();
        check_val("reset_pwm", 64'(pwm_out), 64'd0);
        check_val("reset_ps", 64'(period_start), 64'd0);
        check_val("reset_duty", 64'(duty_rd), 64'(init_vec));
        rst = 0;

        // Reset defaults: 50/50 on every channel, one period_start per period.
        measure(0, -1, 0, 0, h, f, l);
        check_val("init_high", 64'(h), 64'd50);
        check_val("init_first", 64'(f), 64'd0);
        measure(3, -1, 0, 0, h, f, l);
        check_val("init_high_ch3", 64'(h), 64'd50);
        ps_cnt = 0;
        for (int i = 0; i < 2*PERIOD; i++) begin
            cycle();
            ps_cnt += int'(period_start);
        end
        check_val("ps_per_200", 64'(ps_cnt), 64'd2);

        // Held button yields exactly one step.
        press(0);
        wait_ps();
        check_val("inc_once", 64'(duty_of(0)), 64'd60);

        // Saturation at PERIOD and at 0.
        write(0, 95);
        press(0);
        measure(0, -1, 0, 0, h, f, l);
        check_val("sat_hi_duty", 64'(duty_of(0)), 64'd100);
        check_val("sat_hi_high", 64'(h), 64'd100);
        write(0, 5);
        for (int i = 0; i < 10; i++) press(NUM_CH + 0);
        measure(0, -1, 0, 0, h, f, l);
        check_val("sat_lo_duty", 64'(duty_of(0)), 64'd0);
        check_val("sat_lo_high", 64'(h), 64'd0);

        // Mid-period write does not disturb the running period.
        measure(2, 30, 2, 25, h, f, l);
        check_val("wr_mid_cur", 64'(h), 64'd50);
        measure(2, -1, 0, 0, h, f, l);
        check_val("wr_mid_next", 64'(h), 64'd25);
        write(1, 127);
        wait_ps();
        check_val("wr_clamp", 64'(duty_of(1)), 64'd100);

        // Center alignment.
        mode[1] = 1;
        write(1, 20);
        measure(1, -1, 0, 0, h, f, l);
        check_val("ctr20_first", 64'(f), 64'd40);
        check_val("ctr20_last", 64'(l), 64'd59);
        write(1, 15);
        measure(1, -1, 0, 0, h, f, l);
        check_val("ctr15_first", 64'(f), 64'd42);
        check_val("ctr15_last", 64'(l), 64'd56);
        check_val("ctr15_high", 64'(h), 64'd15);

        // Short glitch between ticks and opposing presses are ignored.
        while (n % DT != 0) cycle();
        btn_dec[3] = 1;
        repeat (2) cycle();
        btn_dec[3] = 0;
        repeat (4*DT) cycle();
        wait_ps();
        check_val("glitch", 64'(duty_of(3)), 64'd50);
        write(0, 40);
        btn_inc[0] = 1; btn_dec[0] = 1;
        repeat (3*DT) cycle();
        btn_inc[0] = 0; btn_dec[0] = 0;
        repeat (3*DT) cycle();
        wait_ps();
        check_val("inc_dec_cancel", 64'(duty_of(0)), 64'd40);

        // Reset mid-period.
        mode = '0;
        write(0, 60);
        wait_ps();
        while (n % PERIOD != 70) cycle();
        rst = 1;
        cycle();
        rst = 0;
        check_val("rst_mid_pwm", 64'(pwm_out), 64'd0);
        check_val("rst_mid_duty", 64'(duty_rd), 64'(init_vec));
        measure(0, -1, 0, 0, h, f, l);
        check_val("rst_mid_high", 64'(h), 64'd50);
        check_val("rst_mid_first", 64'(f), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 15) == 0) btn_inc[c] = ~btn_inc[c];
                if ($urandom_range(0, 15) == 0) btn_dec[c] = ~btn_dec[c];
                if ($urandom_range(0, 199) == 0) mode[c] = ~mode[c];
            end
            wr_en   = ($urandom_range(0, 19) == 0);
            wr_ch   = 2'($urandom_range(0, NUM_CH - 1));
            wr_data = CNT_W'($urandom_range(0, 127));
            rst     = ($urandom_range(0, 1499) == 0);
            cycle();
        end
        rst = 0; wr_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
